compute_unit_pipe: RTL and testbench

//  Parametrised 2-stage compute unit: register file plus ALU executing one instruction per beat.

---
 rtl/cu_pkg.sv | 35 +++
 rtl/cu_alu.sv | 49 ++++
 rtl/compute_unit_pipe.sv | 103 ++++++++++
 tb/tb_compute_unit_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, instruction field helpers and ALU result type for compute_unit_pipe
package cu_pkg;
  localparam int MAX_DATA_W = 64;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_SHL  = 4'h2;
  localparam logic [3:0] OP_SHR  = 4'h3;
  localparam logic [3:0] OP_LOAD = 4'h9;
  localparam logic [3:0] OP_ADD  = 4'hA;
  localparam logic [3:0] OP_SUB  = 4'hB;
  localparam logic [3:0] OP_AND  = 4'hC;
  localparam logic [3:0] OP_OR   = 4'hD;
  localparam logic [3:0] OP_NOT  = 4'hE;
  localparam logic [3:0] OP_XOR  = 4'hF;
  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  carry;
    logic                  err;
  } alu_res_t;
  function automatic int instr_w(input int dw, input int aw);
    return 4 + aw + ((2 * aw > dw) ? 2 * aw : dw);
  endfunction
  function automatic int op_lsb(input int iw);
    return iw - 4;
  endfunction
  function automatic int tgt_lsb(input int iw, input int aw);
    return iw - 4 - aw;
  endfunction
  function automatic int src0_lsb(input int iw, input int aw);
    return iw - 4 - 2 * aw;
  endfunction
  function automatic int src1_lsb(input int iw, input int aw);
    return iw - 4 - 3 * aw;
  endfunction
endpackage

// File: rtl/cu_alu.sv
// cu_alu: combinational ALU; CU_LEGACY3OP_EN folds operand c (tgt) into ADD/SUB/AND/OR/XOR
module cu_alu
  import cu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] imm,
  output alu_res_t          res
);
  localparam int XW = DATA_W + 1;
  logic [XW-1:0]     sum, dif;
  logic [DATA_W-1:0] and_v, or_v, xor_v;
`ifdef CU_LEGACY3OP_EN
  assign sum   = XW'(a) + XW'(b) + XW'(c);
  assign dif   = XW'(a) - XW'(b) - XW'(c);
  assign and_v = a & b & c;
  assign or_v  = a | b | c;
  assign xor_v = a ^ b ^ c;
`else
  logic unused_c;
  assign unused_c = ^c;
  assign sum   = XW'(a) + XW'(b);
  assign dif   = XW'(a) - XW'(b);
  assign and_v = a & b;
  assign or_v  = a | b;
  assign xor_v = a ^ b;
`endif
  always_comb begin
    res = '0;
    case (op)
      OP_NOP:  res.data = '0;
      OP_MOV:  res.data = MAX_DATA_W'(a);
      OP_SHL:  begin res.data = MAX_DATA_W'({a[DATA_W-2:0], 1'b0}); res.carry = a[DATA_W-1]; end
      OP_SHR:  begin res.data = MAX_DATA_W'(a[DATA_W-1:1]); res.carry = a[0]; end
      OP_LOAD: res.data = MAX_DATA_W'(imm);
      OP_ADD:  begin res.data = MAX_DATA_W'(sum[DATA_W-1:0]); res.carry = sum[DATA_W]; end
      OP_SUB:  begin res.data = MAX_DATA_W'(dif[DATA_W-1:0]); res.carry = dif[DATA_W]; end
      OP_AND:  res.data = MAX_DATA_W'(and_v);
      OP_OR:   res.data = MAX_DATA_W'(or_v);
      OP_NOT:  res.data = MAX_DATA_W'(~a);
      OP_XOR:  res.data = MAX_DATA_W'(xor_v);
      default: res.err = 1'b1;
    endcase
  end
endmodule

// File: rtl/compute_unit_pipe.sv
// compute_unit_pipe: 2-stage regfile+ALU pipe with forwarding; CU_LEGACY3OP_EN selects 3-operand ALU forms
module compute_unit_pipe
  import cu_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 16,
  localparam int REG_AW   = $clog2(NUM_REGS),
  localparam int INSTR_W  = instr_w(DATA_W, REG_AW)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [REG_AW-1:0]  out_reg,
  output logic               out_zero,
  output logic               out_carry,
  output logic               out_err
);
  localparam int OP_L  = op_lsb(INSTR_W);
  localparam int TGT_L = tgt_lsb(INSTR_W, REG_AW);
  localparam int S0_L  = src0_lsb(INSTR_W, REG_AW);
  localparam int S1_L  = src1_lsb(INSTR_W, REG_AW);
  typedef struct packed {
    logic [3:0]        op;
    logic [REG_AW-1:0] tgt;
    logic [DATA_W-1:0] a, b, c, imm;
  } d_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] rg;
    logic              zero, carry, err;
  } o_t;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  d_t                d_q, d_d;
  o_t                o_q, o_d;
  logic              d_valid_q, d_valid_d, out_valid_q, out_valid_d;
  logic              d_adv, accept, wr, unused_hi;
  logic [REG_AW-1:0] tgt_f, s0_f, s1_f;
  logic [DATA_W-1:0] wdata;
  alu_res_t          res;
  assign tgt_f    = in_instr[TGT_L +: REG_AW];
  assign s0_f     = in_instr[S0_L +: REG_AW];
  assign s1_f     = in_instr[S1_L +: REG_AW];
  assign d_adv    = d_valid_q & ena & (!out_valid_q | out_ready);
  assign in_ready = rst_n & ena & (!d_valid_q | d_adv);
  assign accept   = in_valid & in_ready;
  cu_alu #(.DATA_W(DATA_W)) u_alu (
    .op (d_q.op),
    .a  (d_q.a),
    .b  (d_q.b),
    .c  (d_q.c),
    .imm(d_q.imm),
    .res(res)
  );
  assign wdata     = res.data[DATA_W-1:0];
  assign unused_hi = ^res.data;
  assign wr        = d_adv & (d_q.op != OP_NOP) & !res.err;
  // operands bypass the regfile when the advancing D instruction writes the same register
  always_comb begin
    regs_d = regs_q;
    if (wr) regs_d[d_q.tgt] = wdata;
    d_valid_d = accept | (d_valid_q & !d_adv);
    d_d = d_q;
    if (accept) begin
      d_d.op  = in_instr[OP_L +: 4];
      d_d.tgt = tgt_f;
      d_d.a   = (wr && d_q.tgt == s0_f) ? wdata : regs_q[s0_f];
      d_d.b   = (wr && d_q.tgt == s1_f) ? wdata : regs_q[s1_f];
      d_d.c   = (wr && d_q.tgt == tgt_f) ? wdata : regs_q[tgt_f];
      d_d.imm = in_instr[DATA_W-1:0];
    end
    out_valid_d = d_adv | (out_valid_q & !(ena & out_ready));
    o_d = o_q;
    if (d_adv) o_d = '{data: wdata, rg: d_q.tgt, zero: wdata == '0, carry: res.carry, err: res.err};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '{default: '0};
      d_q         <= '0;
      o_q         <= '0;
      d_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      d_q         <= d_d;
      o_q         <= o_d;
      d_valid_q   <= d_valid_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = o_q.data;
  assign out_reg   = o_q.rg;
  assign out_zero  = o_q.zero;
  assign out_carry = o_q.carry;
  assign out_err   = o_q.err;
endmodule

// File: tb/tb_compute_unit_pipe.sv
// tb_compute_unit_pipe: directed and random stimulus checked against an instruction-level model
module tb_compute_unit_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] in_instr = '0;
  logic        in_ready, out_valid, out_zero, out_carry, out_err;
  logic [7:0]  out_data;
  logic [3:0]  out_reg;
  typedef struct {int data; int rg; int zero; int carry; int err;} beat_t;
  beat_t q[$];
  int regs[16];
  int n_chk = 0, n_fail = 0, wait_n = 0;
  int last_data = -1, last_zero = -1, last_carry = -1, last_err = -1;
  logic acc_seen = 1'b0;
  compute_unit_pipe dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_reg(out_reg), .out_zero(out_zero), .out_carry(out_carry), .out_err(out_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [15:0] ins);
    int op = int'(ins[15:12]);
    int t = int'(ins[11:8]);
    int a = regs[ins[7:4]];
    int b = regs[ins[3:0]];
    int c = regs[ins[11:8]];
    int imm = int'(ins[7:0]);
    int full;
    beat_t e;
`ifdef CU_LEGACY3OP_EN
    int k = 1;
`else
    int k = 0;
`endif
    e = '{data: 0, rg: t, zero: 0, carry: 0, err: 0};
    case (op)
      0: ;
      1: e.data = a;
      2: begin e.data = (a * 2) % 256; e.carry = a / 128; end
      3: begin e.data = a / 2; e.carry = a % 2; end
      9: e.data = imm;
      10: begin full = a + b + k * c; e.data = full % 256; e.carry = (full / 256) % 2; end
      11: begin full = a - b - k * c + 1024; e.data = full % 256; e.carry = (full / 256) % 2; end
      12: e.data = a & b & (k != 0 ? c : 255);
      13: e.data = a | b | (k != 0 ? c : 0);
      14: e.data = 255 - a;
      15: e.data = a ^ b ^ (k != 0 ? c : 0);
      default: e.err = 1;
    endcase
    if (op != 0 && e.err == 0) regs[t] = e.data;
    e.zero = (e.data == 0) ? 1 : 0;
    q.push_back(e);
  endfunction
  task automatic tick();
    beat_t e;
    @(negedge clk);
    if (out_valid && out_ready && ena) begin
      chk("beat_expected", q.size() != 0 ? 1 : 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_data", int'(out_data), e.data);
        chk("out_reg", int'(out_reg), e.rg);
        chk("out_zero", int'(out_zero), e.zero);
        chk("out_carry", int'(out_carry), e.carry);
        chk("out_err", int'(out_err), e.err);
      end
      last_data = int'(out_data); last_zero = int'(out_zero);
      last_carry = int'(out_carry); last_err = int'(out_err);
    end
    acc_seen = in_valid && in_ready;
    if (acc_seen) model(in_instr);
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] ins);
    in_valid = 1'b1; in_instr = ins; wait_n = 0; acc_seen = 1'b0;
    while (!acc_seen && wait_n < 40) begin tick(); wait_n++; end
    chk("accepted", int'(acc_seen), 1);
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 40) begin tick(); n++; end
    chk("drained", q.size(), 0);
  endtask
  function automatic logic [15:0] ri(input int op, input int t, input int s0, input int s1);
    return {4'(op), 4'(t), 4'(s0), 4'(s1)};
  endfunction
  function automatic logic [15:0] li(input int t, input int imm);
    return {4'h9, 4'(t), 8'(imm)};
  endfunction
  initial begin
    logic [7:0] held;
    regs = '{default: 0};
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_zero", int'(out_zero), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // test 1: back-to-back dependent instructions at full rate
    send(li(1, 8'h05)); send(li(2, 8'h03)); send(ri(10, 3, 1, 2));
    chk("t1_no_stall", wait_n, 1);
    drain();
    chk("t1_add", last_data, 8'h08);
    chk("t1_zero", last_zero, 0);
    chk("t1_carry", last_carry, 0);
    // test 2: wraparound add and borrowing subtract
    send(li(1, 8'hFF)); send(li(2, 8'h01)); send(ri(10, 4, 1, 2)); drain();
    chk("t2_add_data", last_data, 0);
    chk("t2_add_zero", last_zero, 1);
    chk("t2_add_carry", last_carry, 1);
    send(ri(11, 5, 2, 1)); drain();
    chk("t2_sub_data", last_data, 8'h02);
    chk("t2_sub_carry", last_carry, 1);
    // test 3: backpressure holds output and stops intake after two accepts
    out_ready = 1'b0;
    send(li(8, 8'h11)); send(li(9, 8'h22));
    in_valid = 1'b1; in_instr = li(10, 8'h33);
    held = out_data;
    repeat (3) begin
      tick();
      chk("t3_in_ready_low", int'(in_ready), 0);
      chk("t3_out_stable", int'(out_data), int'(held));
      chk("t3_out_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    wait_n = 0; acc_seen = 1'b0;
    while (!acc_seen && wait_n < 40) begin tick(); wait_n++; end
    chk("t3_third_accepted", int'(acc_seen), 1);
    drain();
    chk("t3_last", last_data, 8'h33);
    // test 4: forwarding with no stall
    send(li(1, 8'h0A)); send(ri(1, 2, 1, 0));
    chk("t4_no_stall", wait_n, 1);
    drain();
    chk("t4_fwd", last_data, 8'h0A);
    // test 5: illegal opcode, then NOT
    send(16'h5100); drain();
    chk("t5_err", last_err, 1);
    chk("t5_data", last_data, 0);
    send(ri(1, 7, 1, 0)); drain();
    chk("t5_reg_kept", last_data, 8'h0A);
    send(ri(14, 6, 1, 0)); drain();
    chk("t5_not", last_data, 8'hF5);
`ifdef CU_LEGACY3OP_EN
    send(li(1, 2)); send(li(2, 3)); send(li(3, 4)); send(ri(10, 3, 1, 2)); drain();
    chk("leg_add", last_data, 8'h09);
    send(li(3, 1)); send(ri(11, 3, 1, 2)); drain();
    chk("leg_sub", last_data, 8'hFE);
    chk("leg_sub_carry", last_carry, 1);
`endif
    // test 6: async reset with both stages full
    out_ready = 1'b0;
    send(li(4, 8'h44)); send(li(5, 8'h55));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_in_ready", int'(in_ready), 0);
    chk("t6_out_data", int'(out_data), 0);
    q.delete();
    regs = '{default: 0};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(ri(1, i, i, 0));
    drain();
    chk("t6_regs_zero", last_data, 0);
    // random traffic with backpressure and enable gaps
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom % 4) != 0;
      ena = ($urandom % 8) != 0;
      in_valid = ($urandom % 4) != 0;
      in_instr = 16'($urandom);
      tick();
    end
    ena = 1'b1; out_ready = 1'b1;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
